// File: rtl/parity_stride_counter.sv
`default_nettype none
// ============================================================================
//  Module      : parity_stride_counter
//  Description : Parity-restricted stride counter. Steps through only odd
//                (mode=0) or only even (mode=1) values inside the runtime
//                range [base, top], counting up or down by STEP, with
//                synchronous clear, parallel load, enable gating and a
//                registered wrap pulse.
//
//  Parameters  : WIDTH - count width in bits (>= 2)
//                STEP  - stride magnitude (even, so parity is preserved)
//
//  Ports       : clk         in   rising-edge clock
//                reset       in   asynchronous active-low reset
//                en          in   advance one step this cycle
//                clear       in   synchronous return to base
//                load        in   synchronous parallel load
//                load_val    in   [WIDTH] value for load
//                mode        in   0 = odd sequence, 1 = even sequence
//                dir         in   0 = up, 1 = down
//                limit       in   [WIDTH] inclusive upper bound of range
//                count       out  [WIDTH] current value (registered)
//                wrap        out  registered wrap pulse
//                empty_range out  combinational: no legal value in range
//
//  Options     : PARITY_STRIDE_SAT_EN - when defined, counting saturates at
//                the terminal value instead of wrapping, and wrap becomes a
//                level "at bound" flag while en=1.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_stride_counter #(
    parameter int WIDTH = 4,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             empty_range
);

    // Stride held one bit wider than the count so count+STEP never truncates.
    localparam logic [WIDTH:0]   c_step = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] c_lsb  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_rst  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic             w_par;        // required LSB of every legal value
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_down_floor; // smallest count that can step down
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_load_par;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    assign w_par   = ~mode;
    assign w_base  = {{(WIDTH-1){1'b0}}, w_par};
    // Largest value not above limit with the right parity. When limit has the
    // wrong parity this is limit-1; for odd mode with limit=0 it underflows,
    // but that case is caught by w_empty before w_top is ever used.
    assign w_top   = (limit[0] == w_par) ? limit : (limit - c_lsb);
    assign w_empty = (limit < w_base);

    assign w_sum        = {1'b0, r_count} + c_step;
    assign w_down_floor = {1'b0, w_base} + c_step;
    assign w_diff       = r_count - c_step[WIDTH-1:0];

    assign w_load_par     = (load_val & ~c_lsb) | w_base;
    assign w_load_clamped = (w_load_par > w_top) ? w_top : w_load_par;

    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (clear || w_empty) begin
            // An empty range pins the counter at base; clear lands there too.
            w_next_count = w_base;
        end else if (load) begin
            w_next_count = w_load_clamped;
        end else if (en) begin
            if (r_count[0] != w_par) begin
                // Mode changed under us: realign to the start of the sweep.
                w_next_count = dir ? w_top : w_base;
            end else if (r_count > w_top) begin
                // Limit was lowered below the current count.
`ifdef PARITY_STRIDE_SAT_EN
                w_next_count = w_top;
                w_next_wrap  = dir ? (w_top == w_base) : 1'b1;
`else
                w_next_count = dir ? w_top : w_base;
                w_next_wrap  = 1'b1;
`endif
            end else if (!dir) begin
                if (w_sum > {1'b0, w_top}) begin
`ifdef PARITY_STRIDE_SAT_EN
                    w_next_count = w_top;
`else
                    w_next_count = w_base;
`endif
                    w_next_wrap  = 1'b1;
                end else begin
                    w_next_count = w_sum[WIDTH-1:0];
`ifdef PARITY_STRIDE_SAT_EN
                    w_next_wrap  = (w_sum[WIDTH-1:0] == w_top);
`endif
                end
            end else begin
                if ({1'b0, r_count} < w_down_floor) begin
`ifdef PARITY_STRIDE_SAT_EN
                    w_next_count = w_base;
`else
                    w_next_count = w_top;
`endif
                    w_next_wrap  = 1'b1;
                end else begin
                    w_next_count = w_diff;
`ifdef PARITY_STRIDE_SAT_EN
                    w_next_wrap  = (w_diff == w_base);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= c_rst;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign count       = r_count;
    assign wrap        = r_wrap;
    assign empty_range = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_parity_stride_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_stride_counter
//  Description : Self-checking bench for parity_stride_counter (WIDTH=4,
//                STEP=2). A value-list model of the legal sequence is
//                compared against the DUT every falling edge, and directed
//                sequences carry hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_stride_counter;

    localparam int WIDTH = 4;
    localparam int STEP  = 2;

    logic             clk;
    logic             reset;
    logic             en;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             empty_range;

    int n_cmp = 0;
    int n_err = 0;

    parity_stride_counter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .mode        (mode),
        .dir         (dir),
        .limit       (limit),
        .count       (count),
        .wrap        (wrap),
        .empty_range (empty_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int f_base(input bit md);
        return md ? 0 : 1;
    endfunction

    // Search downward from limit for the first value of the wanted parity.
    function automatic int f_top(input bit md, input int lim);
        int t;
        t = lim;
        while (t >= 0 && (t % 2) != (md ? 0 : 1)) t--;
        return t;
    endfunction

    function automatic bit f_empty(input bit md, input int lim);
        return f_top(md, lim) < f_base(md);
    endfunction

    int m_count = 1;
    bit m_wrap  = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int b, t, n, k, idx, par, v;
        if (!reset) begin
            m_count = 1;
            m_wrap  = 1'b0;
        end else begin
            par    = mode ? 0 : 1;
            b      = f_base(mode);
            t      = f_top(mode, int'(limit));
            n      = (t - b) / 2 + 1;   // number of legal values
            k      = STEP / 2;          // stride measured in list positions
            m_wrap = 1'b0;
            if (clear || f_empty(mode, int'(limit))) begin
                m_count = b;
            end else if (load) begin
                v       = (int'(load_val) & 32'hFFFF_FFFE) | par;
                m_count = (v > t) ? t : v;
            end else if (en) begin
                if ((m_count % 2) != par) begin
                    m_count = dir ? t : b;
                end else if (m_count > t) begin
`ifdef PARITY_STRIDE_SAT_EN
                    m_count = t;
                    m_wrap  = !dir || (t == b);
`else
                    m_count = dir ? t : b;
                    m_wrap  = 1'b1;
`endif
                end else begin
                    idx = (m_count - b) / 2;
                    if (!dir) begin
                        if (idx + k > n - 1) begin
`ifdef PARITY_STRIDE_SAT_EN
                            idx = n - 1;
`else
                            idx = 0;
`endif
                            m_wrap = 1'b1;
                        end else begin
                            idx = idx + k;
`ifdef PARITY_STRIDE_SAT_EN
                            m_wrap = (idx == n - 1);
`endif
                        end
                    end else begin
                        if (idx - k < 0) begin
`ifdef PARITY_STRIDE_SAT_EN
                            idx = 0;
`else
                            idx = n - 1;
`endif
                            m_wrap = 1'b1;
                        end else begin
                            idx = idx - k;
`ifdef PARITY_STRIDE_SAT_EN
                            m_wrap = (idx == 0);
`endif
                        end
                    end
                    m_count = b + 2 * idx;
                end
            end
        end
    end

    // Continuous comparison mid-cycle, away from both input changes and edges.
    always @(negedge clk) begin
        check("model_count", count, m_count);
        check("model_wrap", wrap, m_wrap);
        check("model_empty", empty_range, f_empty(mode, int'(limit)));
    end

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_cw(input string name, input int c, input bit w);
        check({name, "_count"}, count, c);
        check({name, "_wrap"}, wrap, w);
    endtask

    initial begin
        int exp_up[6];
        reset = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        mode = 1'b0; dir = 1'b0; limit = 4'd9;
        tick(); tick();
        expect_cw("reset", 1, 1'b0);

        reset = 1'b1;
        en    = 1'b1;

`ifdef PARITY_STRIDE_SAT_EN
        exp_up = '{3, 5, 7, 9, 9, 9};
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_cw("sat_up", exp_up[i], i >= 3);
        end
`else
        // Odd up, limit 9.
        exp_up = '{3, 5, 7, 9, 1, 3};
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_cw("odd_up", exp_up[i], i == 4);
        end

        // Even up, limit 15: realign to 0, sweep to 14, wrap back to 0.
        en = 1'b0; clear = 1'b1;
        tick();
        expect_cw("clear_odd", 1, 1'b0);
        clear = 1'b0; mode = 1'b1; limit = 4'd15; en = 1'b1;
        tick();
        expect_cw("even_realign", 0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            expect_cw("even_up", 2 * i, 1'b0);
        end
        tick();
        expect_cw("even_wrap", 0, 1'b1);

        // Odd down, limit 10 (top 9), starting from 3.
        en = 1'b0; mode = 1'b0; limit = 4'd10; load = 1'b1; load_val = 4'd3;
        tick();
        expect_cw("load3", 3, 1'b0);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        tick(); expect_cw("down_1", 1, 1'b0);
        tick(); expect_cw("down_wrap", 9, 1'b1);
        tick(); expect_cw("down_7", 7, 1'b0);
        en = 1'b0; load = 1'b1; load_val = 4'd12;
        tick(); expect_cw("load_clamp", 9, 1'b0);
        load_val = 4'd4;
        tick(); expect_cw("load_lsb", 5, 1'b0);

        // Single-value range: limit 1, wrap every enabled cycle.
        load = 1'b0; en = 1'b1; dir = 1'b0; limit = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_cw("single_up", 1, 1'b1);
        end
        dir = 1'b1;
        tick(); expect_cw("single_dn", 1, 1'b1);

        // Limit lowered under the current count behaves as a wrap.
        en = 1'b0; dir = 1'b0; limit = 4'd9; load = 1'b1; load_val = 4'd9;
        tick(); expect_cw("load9", 9, 1'b0);
        load = 1'b0; limit = 4'd5; en = 1'b1;
        tick(); expect_cw("lowered_limit", 1, 1'b1);
`endif

        // Priority: clear beats load and en.
        mode = 1'b0; dir = 1'b0; limit = 4'd9; load_val = 4'd7;
        clear = 1'b1; load = 1'b1; en = 1'b1;
        tick(); expect_cw("prio_odd", 1, 1'b0);
        mode = 1'b1;
        tick(); expect_cw("prio_even", 0, 1'b0);
        clear = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0;
        tick(); expect_cw("hold", 0, 1'b0);

        // Empty range: odd mode with limit 0.
        limit = 4'd0; en = 1'b1; load = 1'b1; load_val = 4'd7; dir = 1'b1;
        #1;
        check("empty_flag", empty_range, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_cw("empty_hold", 1, 1'b0);
        end
        load = 1'b0;
        tick(); expect_cw("empty_en", 1, 1'b0);

        // Async reset kills a wrap pulse in flight.
        en = 1'b0; dir = 1'b0; limit = 4'd9; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        check("inflight_wrap", wrap, 1'b1);
        #1 reset = 1'b0;
        #1 expect_cw("async_wrap", 1, 1'b0);
        tick();
        reset = 1'b1;

        // Async reset at count 5, then resume 3, 5.
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        tick(); expect_cw("load5", 5, 1'b0);
        load = 1'b0; en = 1'b1;
        #1 reset = 1'b0;
        #1 expect_cw("async_5", 1, 1'b0);
        tick();
        expect_cw("reset_held", 1, 1'b0);
        reset = 1'b1;
        tick(); expect_cw("resume_3", 3, 1'b0);
        tick(); expect_cw("resume_5", 5, 1'b0);

        // Mixed traffic, checked against the model only.
        for (int i = 0; i < 80; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) mode  = ~mode;
            if ($urandom_range(0, 7) == 0)  dir   = ~dir;
            if ($urandom_range(0, 9) == 0)  limit = 4'($urandom_range(0, 15));
            tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_stride_counter.md
Name: parity_stride_counter

Overview:
- Parametrised successor to the fixed 4-bit odd counter.
- Steps through only odd or only even values in a runtime-bounded range [base, top], counting up or down.
- Supports sync clear, parallel load and enable gating, and emits a registered wrap pulse.
- Used as a sequence or address generator wherever the design needs parity-restricted indices.

Parameters:
- WIDTH, 4, count width in bits (>=2).
- STEP, 2, increment magnitude; must be even so parity is preserved.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- en  input  1  advance one step this cycle
- clear  input  1  synchronous return to start value
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value for load
- mode  input  1  0 = odd sequence, 1 = even sequence
- dir  input  1  0 = up, 1 = down
- limit  input  WIDTH  inclusive upper bound of range
- count  output  WIDTH  current value (registered)
- wrap  output  1  one-cycle pulse, registered, on wrap-around
- empty_range  output  1  combinational; no legal value exists in range

Behaviour:
- Derived values (combinational):
  - base = mode ? 0 : 1
  - top = largest value <= limit with LSB == ~mode
  - empty_range = (limit < base); this is only possible for mode=0 with limit=0
- Reset (reset=0, asynchronous): count=1, wrap=0. Count is released on the first rising edge after reset deasserts.
- Update priority per edge: clear > load > en > hold.
- clear: count<=base, wrap<=0.
- load: count<=load_val with LSB forced to ~mode; clamped to top if greater; wrap<=0.
- Realign: if en=1 and count LSB does not match the mode parity (mode changed), the next count is base (dir=0) or top (dir=1). This is not a wrap and wrap<=0.
- If count > top (limit was lowered), the next enabled step behaves as a wrap.
- Up step, dir=0:
  - compute count+STEP in WIDTH+1 bits; never truncate.
  - if result > top: count<=base, wrap<=1.
  - else count<=result, wrap<=0.
- Down step, dir=1:
  - if count < base+STEP: count<=top, wrap<=1.
  - else count<=count-STEP, wrap<=0.
- empty_range=1: count is held at base and wrap stays 0, regardless of en, load and dir. clear still applies.
- Single-value range (top==base): an enabled step keeps count at base and pulses wrap every cycle.
- en=0 with no clear/load: count holds, wrap<=0.
- Asynchronous reset mid-operation overrides everything immediately, including a wrap pulse in flight.
- Latency: one clock from input to count/wrap. No combinational path from inputs to count.

Optional Feature:
- Macro PARITY_STRIDE_SAT_EN.
- When defined:
  - counting saturates at top (up) or base (down) instead of wrapping.
  - wrap is repurposed as a level "at bound" flag: 1 while count sits at the terminal value for the current dir and en=1.
  - clear/load/realign rules are unchanged.
- When undefined: the wrap-around behaviour above applies, and wrap is a pulse.

Test Plan:
- Odd up, WIDTH=4, limit=9, mode=0, dir=0, en=1 after reset release:
  - count goes 1,3,5,7,9,1,3…
  - wrap=1 only on the cycle count returns to 1.
- Even up, limit=15, mode=1:
  - first enabled edge realigns 1→0.
  - then 0,2,…,14,0 with wrap on the return to 0.
  - no overflow past 15.
- Odd down, limit=10 (top=9), from count=3, dir=1:
  - count goes 3,1,9,7 with wrap on 1→9.
  - load_val=12 gives count=9 (clamped); load_val=4 gives count=5 (LSB forced).
- Priority and boundaries:
  - clear,load,en all 1 in one cycle → count=base.
  - mode=0, limit=0 → empty_range=1, count held at 1, wrap=0.
  - limit=1 with en=1 → count stays 1, wrap pulses every cycle.
- Async reset: drop reset at count=5 between clock edges → count=1 and wrap=0 immediately; counting resumes 3,5 after release.
- With PARITY_STRIDE_SAT_EN, odd up, limit=9: count 1,…,9,9,9 with wrap held at 1 from the first cycle at 9.
